row_serializer_8: RTL
=====================

# row_serializer_8

Four-lane to one-lane registered serializer for the matrix multiplier datapath; the transmit-side counterpart of the 1-to-4 lane demultiplexer. It captures four 8-bit operands, such as one result-matrix row, in a single load. It then emits them one per accepted beat on a single output bus under valid/ready flow control. Lane 0 goes first and lane 3 is flagged as last. It sits between the processing-element array outputs and the byte-wide result/transfer path.

## Interface
Parameters:
- DW, 8, lane and output data width in bits
- LANES, 4, number of lanes; fixed at 4 (selector width 2)

Ports:
- clk  input  1  single clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  in0..in3 hold a complete row to load
- in_ready  output  1  block accepts a row this cycle
- in0, in1, in2, in3  input  DW each  lane operands; sampled only on load
- out  output  DW  serialized data
- out_valid  output  1  out is valid
- out_ready  input  1  downstream accepts out this cycle
- out_last  output  1  current beat is lane 3
- out_sel  output  2  lane index of current beat; present only with ROW_SER_SEL_EN
- busy  output  1  row loaded and not fully sent

## Operation
- States: IDLE, SEND. 2-bit beat counter cnt. Row buffer buf[0..3].
- Load condition: in_valid && in_ready.
- in_ready = (state==IDLE) || (state==SEND && cnt==3 && out_ready). Combinational; permits back-to-back rows with no bubble.
- IDLE behaviour:
  - out_valid=0.
  - On load: buf<=in0..in3, cnt<=0, go SEND.
- SEND behaviour:
  - out_valid=1, out=buf[cnt], out_last=(cnt==3), busy=1.
  - Accept = out_valid && out_ready.
  - Accept with cnt<3: cnt<=cnt+1.
  - Accept with cnt==3 and load: buf reloaded, cnt<=0, stay SEND.
  - Accept with cnt==3 and no load: go IDLE, cnt<=0.
  - No accept: all state held; out, out_last and out_sel stable (no data change while stalled).
- Reset, which overrides load/accept including mid-row:
  - state=IDLE, cnt=0, buf all 0.
  - Outputs: out=0, out_valid=0, out_last=0, out_sel=0, busy=0, in_ready=1 from the first cycle after reset.
  - A partially sent row is discarded.
- Inputs in0..in3 are ignored outside the load cycle.
- out is driven from registered buf and cnt through a 4:1 mux. It carries no combinational path from in*.
- in_valid while in_ready=0 is ignored; the sender must hold in_valid.

## Timing
- Load at edge N: first beat visible (out_valid=1, lane 0) in cycle N+1.
- Continuous out_ready: 4 beats in cycles N+1..N+4. A next row loaded at the edge ending N+4 emits from N+5, giving 100% throughput.
- Minimum row time: 4 cycles. Each stall cycle adds 1.
- out_ready low in IDLE has no effect.
- out_ready may toggle freely. Only accepted beats advance cnt.

## Configuration
- ROW_SER_SEL_EN defined:
  - out_sel port exists and equals cnt while out_valid=1.
  - Its value in IDLE is the held cnt, which is 0.
  - Intended to drive a downstream demux select directly.
- ROW_SER_SEL_EN undefined:
  - out_sel port absent.
  - All other behaviour identical.

## Structure
- Shared package row_ser_pkg:
  - state enum {IDLE, SEND}
  - LANES=4, SEL_W=2, default DW=8
- One natural sub-module: mux4_8, a combinational 4:1 DW-bit selector (buf, cnt -> out). Everything else is in row_serializer_8.

## Test plan
- Reset mid-row: load {0x11,0x22,0x33,0x44}, accept 2 beats, assert rst. Then out_valid=0, in_ready=1, out=0, and the next load starts at lane 0.
- Single row, out_ready=1: load {0x11,0x22,0x33,0x44} at cycle 0. Then out=0x11,0x22,0x33,0x44 in cycles 1-4, out_last only in cycle 4, out_valid=0 in cycle 5.
- Back-to-back: in_valid held with rows A={0x01..0x04} and B={0xA1..0xA4}. Then 8 consecutive beats 01,02,03,04,A1,A2,A3,A4 with no gap, and in_ready high in cycle 0 and in cycle 4.
- Backpressure: out_ready=0 for 3 cycles during beat 2 (0x33). Then out stays 0x33, cnt/out_sel stay 2, and the sequence resumes with 0x44.
- Load blocked: in_valid with new data {0xFF..} while in SEND at cnt=1. Then in_ready=0, buf unchanged, and the current row completes intact.
- ROW_SER_SEL_EN: out_sel reads 0,1,2,3 aligned with each beat. The build without the macro passes all other scenarios.

Source files
------------

// File: rtl/row_ser_pkg.sv
// row_ser_pkg: shared types and sizes for the row serializer (out_sel gated by ROW_SER_SEL_EN)
package row_ser_pkg;
  typedef enum logic {IDLE, SEND} state_t;
  localparam int LANES = 4;
  localparam int SEL_W = 2;
  localparam int DEF_DW = 8;
endpackage

// File: rtl/row_serializer_8_if.sv
// row_serializer_8_if: row load and serialized beat handshakes; out_sel exists only with ROW_SER_SEL_EN
interface row_serializer_8_if import row_ser_pkg::*; #(parameter int DW = DEF_DW);
  logic in_valid;
  logic in_ready;
  logic [DW-1:0] in0;
  logic [DW-1:0] in1;
  logic [DW-1:0] in2;
  logic [DW-1:0] in3;
  logic [DW-1:0] out;
  logic out_valid;
  logic out_ready;
  logic out_last;
`ifdef ROW_SER_SEL_EN
  logic [SEL_W-1:0] out_sel;
`endif
  logic busy;
  modport master (
    output in_valid, in0, in1, in2, in3, out_ready,
`ifdef ROW_SER_SEL_EN
    input out_sel,
`endif
    input in_ready, out, out_valid, out_last, busy
  );
  modport slave (
    input in_valid, in0, in1, in2, in3, out_ready,
`ifdef ROW_SER_SEL_EN
    output out_sel,
`endif
    output in_ready, out, out_valid, out_last, busy
  );
endinterface

// File: rtl/row_serializer_8_mux4.sv
// mux4_8: combinational 4:1 lane selector from the registered row buffer
module mux4_8 import row_ser_pkg::*; #(parameter int DW = DEF_DW) (
  input  logic [DW-1:0]    d [LANES],
  input  logic [SEL_W-1:0] sel,
  output logic [DW-1:0]    y
);
  assign y = d[sel];
endmodule

// File: rtl/row_serializer_8.sv
// row_serializer_8: loads a 4-lane row and emits it lane 0 first under valid/ready (out_sel with ROW_SER_SEL_EN)
module row_serializer_8 import row_ser_pkg::*; #(parameter int DW = DEF_DW) (
  input logic clk,
  input logic rst,
  row_serializer_8_if.slave bus
);
  state_t state, state_nx;
  logic [SEL_W-1:0] cnt;
  logic [DW-1:0] row_buf [LANES];
  logic last, load, accept;
  assign last = cnt == SEL_W'(LANES - 1);
  assign load = bus.in_valid && bus.in_ready;
  assign accept = bus.out_valid && bus.out_ready;
  always_ff @(posedge clk)
    state <= rst ? IDLE : state_nx;
  always_comb
    state_nx = load ? SEND : (accept && last) ? IDLE : state;
  // in_ready on the final accepted beat lets the next row follow with no bubble
  always_comb begin
    bus.out_valid = state == SEND;
    bus.busy = state == SEND;
    bus.out_last = state == SEND && last;
    bus.in_ready = state == IDLE || (state == SEND && last && bus.out_ready);
  end
  always_ff @(posedge clk)
    if (rst) cnt <= '0;
    else if (load) cnt <= '0;
    else if (accept) cnt <= cnt + 1'b1;
  always_ff @(posedge clk)
    if (rst) row_buf <= '{default: '0};
    else if (load) row_buf <= '{bus.in0, bus.in1, bus.in2, bus.in3};
  mux4_8 #(.DW(DW)) u_mux (.d(row_buf), .sel(cnt), .y(bus.out));
`ifdef ROW_SER_SEL_EN
  assign bus.out_sel = cnt;
`endif
endmodule
